// File: rtl/hex_shift_register.sv
// hex_shift_register
//   WIDTH-bit hold / parallel-load / shift-left / shift-right register with
//   optional rotate. It counts the shifts made since the last load (the count
//   saturates at WIDTH), flags when a full serial word has entered, and drives
//   one active-low seven-segment digit per nibble of q.
//
// Build option: define HEX_DECODE_EN to include the nibble decoders. Without
//   it, hex is tied to all ones (every segment off) and keeps its width.
//
// Parameters
//   WIDTH        register width, a multiple of 4 and at least 4
//   RESET_VALUE  value loaded into q on reset
//   CW           shift counter width (derived, do not override)
// Ports
//   clock   rising-edge clock
//   reset   synchronous active-high reset; overrides every other input
//   en      clock enable; when low, all state holds
//   mode    00 hold, 01 load, 10 shift left, 11 shift right
//   rot     in shift modes, rotate instead of taking sin
//   sin     serial input bit
//   d       parallel load data
//   q       register contents
//   sout    registered copy of the last bit shifted out
//   count   shifts since the last load or reset, saturating at WIDTH
//   full    high when count == WIDTH
//   hex     active-low gfedcba digits; digit i = hex[7i+6:7i], shows q[4i+3:4i]

module hex_seg_digit (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module hex_shift_register #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int                CW          = $clog2(WIDTH+1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic                   rot,
  input  logic                   sin,
  input  logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q,
  output logic                   sout,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic [7*(WIDTH/4)-1:0] hex
);
  localparam int DIGITS = WIDTH / 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_LOAD  = 2'b01;
  localparam logic [1:0] M_LEFT  = 2'b10;
  localparam logic [1:0] M_RIGHT = 2'b11;

  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;
  logic [CW-1:0]    count_nxt;
  logic             in_l, in_r;

  // Rotate feeds back the bit leaving the opposite end.
  assign in_l = rot ? q[WIDTH-1] : sin;
  assign in_r = rot ? q[0]       : sin;

  always_comb begin
    q_nxt     = q;
    sout_nxt  = sout;
    count_nxt = count;
    if (en) begin
      case (mode)
        M_HOLD: ;
        M_LOAD: begin
          q_nxt     = d;
          count_nxt = '0;
        end
        M_LEFT: begin
          q_nxt    = {q[WIDTH-2:0], in_l};
          sout_nxt = q[WIDTH-1];
          if (count != CNT_MAX) count_nxt = count + 1'b1;
        end
        M_RIGHT: begin
          q_nxt    = {in_r, q[WIDTH-1:1]};
          sout_nxt = q[0];
          if (count != CNT_MAX) count_nxt = count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // full is registered from the next count so it moves on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= RESET_VALUE;
      sout  <= 1'b0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      q     <= q_nxt;
      sout  <= sout_nxt;
      count <= count_nxt;
      full  <= (count_nxt == CNT_MAX);
    end
  end

`ifdef HEX_DECODE_EN
  logic [DIGITS-1:0][6:0] seg;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    hex_seg_digit u_dig (
      .nib (q[4*i +: 4]),
      .seg (seg[i])
    );
  end
  assign hex = seg;
`else
  assign hex = '1;
`endif

endmodule

// File: tb/tb_hex_shift_register.sv
// Directed bench for hex_shift_register (WIDTH=8, RESET_VALUE=8'hA5).
// Expected hex follows the build: decoded digits with HEX_DECODE_EN,
// all ones without it.
module tb_hex_shift_register;
  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clock = 1'b0;
  logic          reset, en, rot, sin;
  logic [1:0]    mode;
  logic [W-1:0]  d, q;
  logic          sout, full;
  logic [CW-1:0] count;
  logic [13:0]   hex;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  hex_shift_register #(.WIDTH(W), .RESET_VALUE(8'hA5)) dut (
    .clock (clock), .reset (reset), .en (en), .mode (mode), .rot (rot),
    .sin (sin), .d (d), .q (q), .sout (sout), .count (count),
    .full (full), .hex (hex)
  );

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [13:0] exp_hex(input logic [7:0] v);
`ifdef HEX_DECODE_EN
    return {seg7(v[7:4]), seg7(v[3:0])};
`else
    return 14'h3FFF;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; en = 0; mode = 2'b10; rot = 0; sin = 1; d = 8'h00;
    step();
    reset = 0;
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q got=%h exp=a5", q); end
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout got=%b exp=0", sout); end
    checks++; if (hex !== exp_hex(8'hA5)) begin errors++; $display("FAIL reset_hex got=%h exp=%h", hex, exp_hex(8'hA5)); end
  endtask

  task automatic test_shift_left();
    logic [7:0] eq [8] = '{8'h79, 8'hF3, 8'hE7, 8'hCF, 8'h9F, 8'h3F, 8'h7F, 8'hFF};
    logic       es [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    en = 1; mode = 2'b01; d = 8'h3C;
    step();
    checks++; if (q !== 8'h3C || count !== 0) begin errors++; $display("FAIL load_3c q=%h count=%0d exp q=3c count=0", q, count); end
    mode = 2'b10; sin = 1; rot = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (q !== eq[i] || sout !== es[i] || count !== CW'(i+1) || full !== (i == 7)) begin
        errors++;
        $display("FAIL shl_%0d q=%h sout=%b count=%0d full=%b exp q=%h sout=%b count=%0d full=%b",
                 i, q, sout, count, full, eq[i], es[i], i+1, (i == 7));
      end
    end
    step();
    checks++; if (count !== 4'd8 || full !== 1'b1 || q !== 8'hFF || sout !== 1'b1) begin
      errors++; $display("FAIL shl_saturate q=%h sout=%b count=%0d full=%b exp q=ff sout=1 count=8 full=1", q, sout, count, full);
    end
  endtask

  task automatic test_load_full_rotate();
    logic [7:0] eq [8] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
    logic       es [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
    mode = 2'b01; d = 8'h81;
    step();
    checks++; if (q !== 8'h81 || count !== 0 || full !== 0 || sout !== 1'b1) begin
      errors++; $display("FAIL load_when_full q=%h count=%0d full=%b sout=%b exp q=81 count=0 full=0 sout=1", q, count, full, sout);
    end
    mode = 2'b11; rot = 1; sin = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (q !== eq[i] || sout !== es[i] || count !== CW'(i+1) || full !== (i == 7)) begin
        errors++;
        $display("FAIL rotr_%0d q=%h sout=%b count=%0d full=%b exp q=%h sout=%b count=%0d full=%b",
                 i, q, sout, count, full, eq[i], es[i], i+1, (i == 7));
      end
    end
  endtask

  task automatic test_enable_hold();
    en = 0; mode = 2'b10; rot = 0; sin = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (q !== 8'h81 || count !== 4'd8 || sout !== 1'b1 || full !== 1'b1) begin
        errors++; $display("FAIL en_hold_%0d q=%h count=%0d sout=%b full=%b exp q=81 count=8 sout=1 full=1", i, q, count, sout, full);
      end
    end
    en = 1; mode = 2'b00;
    step();
    checks++; if (q !== 8'h81 || count !== 4'd8) begin errors++; $display("FAIL mode_hold q=%h count=%0d exp q=81 count=8", q, count); end
  endtask

  task automatic test_reset_mid_shift();
    en = 1; mode = 2'b01; d = 8'h0F;
    step();
    mode = 2'b10; rot = 0; sin = 0;
    step();
    step();
    checks++; if (q !== 8'h3C || count !== 2) begin errors++; $display("FAIL pre_reset q=%h count=%0d exp q=3c count=2", q, count); end
    reset = 1;
    step();
    reset = 0;
    checks++; if (q !== 8'hA5 || count !== 0 || full !== 0 || sout !== 0) begin
      errors++; $display("FAIL mid_reset q=%h count=%0d full=%b sout=%b exp q=a5 count=0 full=0 sout=0", q, count, full, sout);
    end
    step();
    checks++; if (q !== 8'h4A || count !== 1 || sout !== 1'b1) begin
      errors++; $display("FAIL post_reset_shift q=%h count=%0d sout=%b exp q=4a count=1 sout=1", q, count, sout);
    end
  endtask

  task automatic test_hex();
    logic [7:0] vals [4] = '{8'h00, 8'h12, 8'h9E, 8'hBD};
    en = 1; mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      d = vals[i];
      step();
      checks++;
      if (q !== vals[i] || hex !== exp_hex(vals[i])) begin
        errors++; $display("FAIL hex_%h q=%h hex=%h exp q=%h hex=%h", vals[i], q, hex, vals[i], exp_hex(vals[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_load_full_rotate();
    test_enable_hold();
    test_reset_mid_shift();
    test_hex();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
